// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding decode with pc/inst/prediction.
// Build option: BRANCH_PREDICT_EN adds a 2-bit-counter branch history table.
//
// Ports:
//   clk_in, rst_in             clock, async active-low reset
//   mem_req_out/mem_addr_out   byte read request and address to memory
//   mem_ack_in/mem_byte_in     request accepted, returned byte (same cycle)
//   stall_in                   decode cannot take the presented instruction
//   jump_in/jump_target_in     execute redirect, overrides everything
//   bht_we_in/bht_pc_in/
//   bht_taken_in               resolved-branch training port
//   pc_out/inst_out/valid_out/
//   pre_to_take_out            presented instruction and its prediction
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BHT_BITS = 7
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [7:0]  mem_byte_in,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_target_in,
    input  logic        bht_we_in,
    input  logic [31:0] bht_pc_in,
    input  logic        bht_taken_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out,
    output logic        pre_to_take_out
);

    typedef enum logic {
        FETCH   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_n;
    logic [31:0] pc_q;
    logic [31:0] pc_n;
    logic [1:0]  k_q;
    logic [1:0]  k_n;
    logic [23:0] lo_q;
    logic [31:0] npc_q;
    logic        pre_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] pco_q;

    logic        accept;
    logic        last;
    logic        consume;
    logic [31:0] word;
    logic [31:0] b_imm;
    logic        predict;
    logic [31:0] npc_calc;

    // An ack only counts while a request is actually on the bus.
    assign accept  = (state_q == FETCH) && req_q && mem_ack_in;
    assign last    = accept && (k_q == 2'd3);
    assign consume = (state_q == PRESENT) && !stall_in;

    // Word as it will look once the current byte lands.
    assign word = {mem_byte_in, lo_q};

    assign b_imm = {{19{word[31]}}, word[31], word[7],
                    word[30:25], word[11:8], 1'b0};

    assign npc_calc = predict ? (pc_q + b_imm) : (pc_q + 32'd4);

`ifdef BRANCH_PREDICT_EN
    localparam int unsigned BHT_N = 1 << BHT_BITS;

    logic [1:0]          bht_q [BHT_N];
    logic [BHT_BITS-1:0] rd_idx;
    logic [BHT_BITS-1:0] wr_idx;
    logic                unused_bht_pc;

    assign rd_idx = pc_q[BHT_BITS+1:2];
    assign wr_idx = bht_pc_in[BHT_BITS+1:2];

    assign unused_bht_pc = ^{bht_pc_in[31:BHT_BITS+2], bht_pc_in[1:0]};

    // Reads see the registered counter, so a same-cycle update
    // of the looked-up entry only affects later lookups.
    assign predict = (word[6:0] == 7'b1100011) && bht_q[rd_idx][1];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_we_in) begin
            if (bht_taken_in && bht_q[wr_idx] != 2'b11) begin
                bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
            end else if (!bht_taken_in && bht_q[wr_idx] != 2'b00) begin
                bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
            end
        end
    end
`else
    localparam int unsigned unused_bht_bits = BHT_BITS;

    logic unused_bht_port;

    assign unused_bht_port = ^{bht_we_in, bht_pc_in, bht_taken_in};
    assign predict         = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        k_n     = k_q;
        if (jump_in) begin
            state_n = FETCH;
            pc_n    = jump_target_in;
            k_n     = 2'd0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (accept) begin
                        k_n = k_q + 2'd1;
                        if (last) begin
                            state_n = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (consume) begin
                        state_n = FETCH;
                        pc_n    = npc_q;
                        k_n     = 2'd0;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            k_q     <= k_n;
        end
    end

    // Bus outputs are registered from the next state so they are
    // glitch-free and the address holds while a byte is unacked.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            req_q  <= 1'b0;
            addr_q <= 32'd0;
        end else begin
            req_q  <= (state_n == FETCH);
            addr_q <= pc_n + {30'd0, k_n};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lo_q <= 24'd0;
        end else if (accept && !jump_in) begin
            case (k_q)
                2'd0:    lo_q[7:0]   <= mem_byte_in;
                2'd1:    lo_q[15:8]  <= mem_byte_in;
                2'd2:    lo_q[23:16] <= mem_byte_in;
                default: lo_q        <= lo_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            inst_q <= 32'd0;
            pco_q  <= 32'd0;
            npc_q  <= 32'd0;
            pre_q  <= 1'b0;
        end else if (jump_in) begin
            pre_q <= 1'b0;
        end else if (last) begin
            inst_q <= word;
            pco_q  <= pc_q;
            npc_q  <= npc_calc;
            pre_q  <= predict;
        end else if (consume) begin
            pre_q <= 1'b0;
        end
    end

    assign mem_req_out     = req_q;
    assign mem_addr_out    = addr_q;
    assign inst_out        = inst_q;
    assign pc_out          = pco_q;
    assign valid_out       = (state_q == PRESENT);
    assign pre_to_take_out = pre_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a byte memory responder.
// Expected values are hand-derived; BRANCH_PREDICT_EN selects branch results.
module tb_if_fetch;

    logic        clk_in;
    logic        rst_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in;
    logic [7:0]  mem_byte_in;
    logic        stall_in;
    logic        jump_in;
    logic [31:0] jump_target_in;
    logic        bht_we_in;
    logic [31:0] bht_pc_in;
    logic        bht_taken_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic        pre_to_take_out;

    logic [7:0]  mem [512];
    int          delay;
    int          wait_cnt;
    logic        force_ack;
    int          n_chk;
    int          n_fail;

`ifdef BRANCH_PREDICT_EN
    localparam logic        EXP_PRE  = 1'b1;
    localparam logic [31:0] EXP_NPC  = 32'h0000_0018;
    localparam logic [31:0] EXP_INST = 32'h0050_0293;
`else
    localparam logic        EXP_PRE  = 1'b0;
    localparam logic [31:0] EXP_NPC  = 32'h0000_0024;
    localparam logic [31:0] EXP_INST = 32'h0060_0313;
`endif

    if_fetch dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_byte_in     (mem_byte_in),
        .stall_in        (stall_in),
        .jump_in         (jump_in),
        .jump_target_in  (jump_target_in),
        .bht_we_in       (bht_we_in),
        .bht_pc_in       (bht_pc_in),
        .bht_taken_in    (bht_taken_in),
        .pc_out          (pc_out),
        .inst_out        (inst_out),
        .valid_out       (valid_out),
        .pre_to_take_out (pre_to_take_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    assign mem_byte_in = mem[mem_addr_out[8:0]];
    assign mem_ack_in  = force_ack ||
                         (mem_req_out && (wait_cnt >= delay));

    always_ff @(posedge clk_in) begin
        if (!mem_req_out || mem_ack_in) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put32(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        wait_cnt       = 0;
        delay          = 0;
        force_ack      = 1'b0;
        rst_in         = 1'b0;
        stall_in       = 1'b0;
        jump_in        = 1'b0;
        jump_target_in = 32'd0;
        bht_we_in      = 1'b0;
        bht_pc_in      = 32'd0;
        bht_taken_in   = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        put32(32'h000, 32'h0010_0093);
        put32(32'h004, 32'h0020_0113);
        put32(32'h008, 32'h0040_0213);
        put32(32'h018, 32'h0050_0293);
        put32(32'h020, 32'hFE00_0CE3);
        put32(32'h024, 32'h0060_0313);
        put32(32'h100, 32'h0030_0193);

        step();
        step();
        chk("rst_req", {31'd0, mem_req_out}, 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_pre", {31'd0, pre_to_take_out}, 32'd0);
        rst_in = 1'b1;

        step();
        chk("f0_addr", mem_addr_out, 32'd0);
        chk("f0_req", {31'd0, mem_req_out}, 32'd1);
        for (int b = 1; b < 4; b++) begin
            step();
            chk("f0_addr", mem_addr_out, b);
        end
        step();
        chk("f0_valid", {31'd0, valid_out}, 32'd1);
        chk("f0_inst", inst_out, 32'h0010_0093);
        chk("f0_pc", pc_out, 32'd0);
        chk("f0_req_off", {31'd0, mem_req_out}, 32'd0);
        stall_in     = 1'b1;
        bht_we_in    = 1'b1;
        bht_pc_in    = 32'h20;
        bht_taken_in = 1'b1;

        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_valid", {31'd0, valid_out}, 32'd1);
            chk("stall_inst", inst_out, 32'h0010_0093);
            chk("stall_pc", pc_out, 32'd0);
        end
        stall_in  = 1'b0;
        bht_we_in = 1'b0;

        step();
        chk("rel_valid", {31'd0, valid_out}, 32'd0);
        chk("rel_req", {31'd0, mem_req_out}, 32'd1);
        delay = 2;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 3; c++) begin
                chk("slow_addr", mem_addr_out, 32'd4 + b);
                chk("slow_req", {31'd0, mem_req_out}, 32'd1);
                chk("slow_valid", {31'd0, valid_out}, 32'd0);
                step();
            end
        end
        chk("slow_valid", {31'd0, valid_out}, 32'd1);
        chk("slow_inst", inst_out, 32'h0020_0113);
        chk("slow_pc", pc_out, 32'd4);
        delay = 0;

        step();
        chk("j0_addr", mem_addr_out, 32'd8);
        step();
        chk("j0_addr", mem_addr_out, 32'd9);
        step();
        chk("j0_addr", mem_addr_out, 32'd10);
        jump_in        = 1'b1;
        jump_target_in = 32'h100;
        step();
        jump_in = 1'b0;
        chk("j0_tgt", mem_addr_out, 32'h100);
        chk("j0_req", {31'd0, mem_req_out}, 32'd1);
        chk("j0_valid", {31'd0, valid_out}, 32'd0);
        for (int b = 1; b < 4; b++) begin
            step();
            chk("j0_addr", mem_addr_out, 32'h100 + b);
            chk("j0_valid", {31'd0, valid_out}, 32'd0);
        end
        step();
        chk("j0_valid", {31'd0, valid_out}, 32'd1);
        chk("j0_inst", inst_out, 32'h0030_0193);
        chk("j0_pc", pc_out, 32'h100);

        stall_in       = 1'b1;
        jump_in        = 1'b1;
        jump_target_in = 32'h20;
        step();
        jump_in  = 1'b0;
        stall_in = 1'b0;
        chk("j1_valid", {31'd0, valid_out}, 32'd0);
        chk("j1_pre", {31'd0, pre_to_take_out}, 32'd0);
        chk("j1_addr", mem_addr_out, 32'h20);
        chk("j1_req", {31'd0, mem_req_out}, 32'd1);
        for (int b = 1; b < 4; b++) begin
            step();
            chk("j1_addr", mem_addr_out, 32'h20 + b);
        end
        step();
        chk("br_valid", {31'd0, valid_out}, 32'd1);
        chk("br_inst", inst_out, 32'hFE00_0CE3);
        chk("br_pc", pc_out, 32'h20);
        chk("br_pre", {31'd0, pre_to_take_out}, {31'd0, EXP_PRE});

        step();
        chk("br_npc", mem_addr_out, EXP_NPC);
        chk("br_valid", {31'd0, valid_out}, 32'd0);
        chk("br_pre", {31'd0, pre_to_take_out}, 32'd0);
        for (int b = 1; b < 4; b++) step();
        step();
        chk("t_valid", {31'd0, valid_out}, 32'd1);
        chk("t_inst", inst_out, EXP_INST);
        chk("t_pc", pc_out, EXP_NPC);

        stall_in  = 1'b1;
        force_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("idle_valid", {31'd0, valid_out}, 32'd1);
            chk("idle_inst", inst_out, EXP_INST);
            chk("idle_req", {31'd0, mem_req_out}, 32'd0);
        end
        stall_in  = 1'b0;
        force_ack = 1'b0;
        step();
        chk("t_next", mem_addr_out, EXP_NPC + 32'd4);
        step();
        chk("t_next", mem_addr_out, EXP_NPC + 32'd5);

        rst_in = 1'b0;
        #1;
        chk("mrst_req", {31'd0, mem_req_out}, 32'd0);
        chk("mrst_addr", mem_addr_out, 32'd0);
        chk("mrst_valid", {31'd0, valid_out}, 32'd0);
        chk("mrst_pc", pc_out, 32'd0);
        chk("mrst_inst", inst_out, 32'd0);
        step();
        rst_in = 1'b1;
        step();
        chk("mrst_addr", mem_addr_out, 32'd0);
        chk("mrst_req", {31'd0, mem_req_out}, 32'd1);
        for (int b = 1; b < 4; b++) begin
            step();
            chk("mrst_addr", mem_addr_out, b);
        end
        step();
        chk("mrst_valid", {31'd0, valid_out}, 32'd1);
        chk("mrst_inst", inst_out, 32'h0010_0093);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. It is the producer side of the decode stage's pc/inst/pre_to_take input.
- Reads each 32-bit instruction from the byte-wide memory controller as four little-endian byte handshakes.
- Holds the assembled instruction for decode, with an optional branch prediction.
- Handles stall from stall control and PC redirect (flush) from execute.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BHT_BITS, 7, log2 of the number of branch-history entries (used only with the optional feature).

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- mem_req_out  output  1  byte read request.
- mem_addr_out  output  32  byte address; held stable while mem_req_out=1 and mem_ack_in=0.
- mem_ack_in  input  1  request accepted; mem_byte_in is valid in the same cycle.
- mem_byte_in  input  8  returned byte.
- stall_in  input  1  decode/stall control cannot accept this cycle.
- jump_in  input  1  execute redirect (mispredict or jump).
- jump_target_in  input  32  redirect PC.
- bht_we_in  input  1  branch resolved in execute.
- bht_pc_in  input  32  PC of the resolved branch.
- bht_taken_in  input  1  actual branch outcome.
- pc_out  output  32  PC of the presented instruction.
- inst_out  output  32  presented instruction.
- valid_out  output  1  pc_out/inst_out are meaningful.
- pre_to_take_out  output  1  predicted taken.

Behaviour:
- **Reset (rst_in=0, async):**
  - State FETCH, pc=RESET_PC, byte counter k=0.
  - mem_req_out=0, mem_addr_out=0, inst_out=0, pc_out=0, valid_out=0, pre_to_take_out=0.
  - All BHT entries set to 2'b01.
- **FETCH:**
  - mem_req_out=1, mem_addr_out=pc+k.
  - On mem_ack_in, mem_byte_in is stored to inst byte k, and k increments.
  - On the ack with k=3, go to PRESENT. Next_pc and prediction are computed from the assembled word in that same edge.
- **PRESENT:**
  - valid_out=1, mem_req_out=0.
  - pc_out and inst_out are registered and stable for the whole stay.
  - If stall_in=0 at the edge, the instruction is consumed: pc<=next_pc, k<=0, go to FETCH, and valid_out drops the next cycle.
  - If stall_in=1, stay in PRESENT with outputs unchanged.
- **next_pc:**
  - pc+4 (32-bit wrap, no overflow check), unless the predictor says taken.
  - If predicted taken, next_pc = pc + B-immediate, with B-imm = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
- **Minimum latency:** 4 ack cycles, then 1 PRESENT cycle. Throughput is at most 1 instruction per 5 cycles.
- **jump_in=1 (highest priority, any state):**
  - Takes priority over stall_in and over a same-cycle mem_ack_in; that byte is discarded.
  - pc<=jump_target_in, k<=0, state<=FETCH.
  - valid_out and pre_to_take_out are 0 from the next cycle.
  - No partial instruction is ever presented.
- **Idle memory:** mem_ack_in while mem_req_out=0 is ignored.
- **Misaligned jump_target_in:** fetched as given, byte-wise. No alignment trap.
- **Reset mid-fetch:** partial bytes are lost and the fetch restarts at RESET_PC.

Optional Feature:
- Macro BRANCH_PREDICT_EN.
- **Defined:** BHT of 2^BHT_BITS 2-bit saturating counters, indexed by pc[BHT_BITS+1:2].
  - Prediction: opcode 7'b1100011 and counter[1]=1 gives pre_to_take_out=1 and the taken next_pc.
  - Update on bht_we_in: increment if bht_taken_in, else decrement, saturating at 0 and 3.
  - Simultaneous update and lookup of the same index: lookup uses the old value.
- **Undefined:** no BHT storage. pre_to_take_out is constant 0, next_pc is always pc+4, and the bht_* inputs are ignored.

Test Plan:
- **Basic fetch:** reset release, memory holds bytes 93,00,10,00 at 0..3 with immediate acks -> mem_addr_out 0,1,2,3. Then valid_out=1, inst_out=32'h0010_0093, pc_out=0. The next fetch starts at addr 4.
- **Stall hold:** stall_in=1 for 3 cycles during PRESENT -> valid_out stays 1 and inst_out/pc_out are unchanged. On release, the next fetch begins at pc_out+4.
- **Slow memory:** ack is delayed 2 cycles per byte -> mem_addr_out is held stable while unacked, and the instruction is correct after 12 cycles.
- **Redirect during fetch:** jump_in=1 with target 32'h100 at k=2, with a simultaneous ack -> that byte is dropped, mem_addr_out=32'h100 next cycle, and no valid_out for the aborted instruction.
- **Redirect during PRESENT+stall:** jump_in and stall_in both high -> valid_out=0 next cycle and the fetch restarts at the target.
- **BRANCH_PREDICT_EN:** three bht_we_in taken updates for pc 32'h20, then fetch of a beq at 32'h20 with imm=-8 -> pre_to_take_out=1 and the next fetch is at 32'h18. Without the macro -> pre_to_take_out=0 and the next fetch is at 32'h24.
